mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external word-granular memory port between the instruction cache (port 0) and the data cache (port 1).
- Each cache connects its external memory interface to one requester port; the arbiter's memory-side ports drive the real memory.
- Grants one owner at a time and holds the grant across a full line fill or write-through.
- Tracks outstanding reads and routes in-order read responses back to the owner.

Parameters:
- MAX_OUT, 4: maximum accepted-but-unanswered reads; equals the words per cache line.
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 1 always wins simultaneous requests.

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  synchronous active-high reset
- i_mem_ready  in  1  memory accepts a request this cycle
- o_mem_addr  out  32  request address, word aligned
- o_mem_ren  out  1  read request
- o_mem_wen  out  1  write request
- o_mem_wdata  out  32  write data
- i_mem_rdata  in  32  read response data
- i_mem_valid  in  1  read response valid; responses arrive in request order
- i_p0_addr, i_p1_addr  in  32  requester address
- i_p0_ren, i_p1_ren  in  1  requester read
- i_p0_wen, i_p1_wen  in  1  requester write
- i_p0_wdata, i_p1_wdata  in  32  requester write data
- o_p0_ready, o_p1_ready  out  1  forwarded ready
- o_p0_rdata, o_p1_rdata  out  32  forwarded read data
- o_p0_valid, o_p1_valid  out  1  forwarded read valid
- o_grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous and active-high.
- Transfers:
  - A transfer occurs when o_mem_ren or o_mem_wen is high in the same cycle as i_mem_ready.
  - Writes produce no response.
  - Each read produces exactly one i_mem_valid, at least 1 cycle later.
- Requester rule: each requester drives ren/wen independently of its ready input. ren and wen are never both high.
- Reset: state=IDLE, owner=none, out_cnt=0, last_winner=port 1. While in reset and in IDLE, every output is 0.
- State IDLE:
  - No memory request is driven and both readies are 0.
  - If any port has ren|wen, latch the winner and go to OWN next cycle.
  - Request seen in cycle N → first memory request possible in cycle N+1.
- Arbitration when both ports request:
  - FIXED_PRIO=0: the port other than last_winner wins.
  - FIXED_PRIO=1: port 1 wins.
  - last_winner updates on every grant.
- State OWN:
  - o_mem_addr/ren/wen/wdata are muxed from the owner.
  - o_pX_ready = i_mem_ready for the owner, 0 for the other port.
  - Forced 0 when out_cnt==MAX_OUT; in that case o_mem_ren/wen are also masked to 0.
- State DRAIN: entered from OWN when the owner drops both ren and wen while out_cnt>0.
  - No memory requests are driven.
  - If the owner re-asserts ren/wen, return to OWN (same owner).
- Release:
  - From OWN or DRAIN, go to IDLE when the owner's ren|wen is 0 and the next-cycle out_cnt is 0.
  - The other port may then win in the following cycle.
- out_cnt (width clog2(MAX_OUT+1)):
  - +1 on an accepted read.
  - −1 on i_mem_valid.
  - Unchanged when both happen in the same cycle.
- Responses:
  - o_pX_rdata = i_mem_rdata and o_pX_valid = i_mem_valid, owner only, combinational.
  - The non-owner sees valid=0 and rdata=0.
  - i_mem_valid with out_cnt==0 is dropped; the counter does not underflow.
- Reset mid-transfer: returns to IDLE and clears out_cnt; late memory responses are dropped.
- Memory outputs are always driven from the owner's inputs; a non-owner request never reaches memory.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'b00, OWN=2'b01, DRAIN=2'b10;
  - port indices PORT_I=0, PORT_D=1;
  - the MAX_OUT default, shared with the cache line-size constants.
- One natural sub-module: mem_arb_pick, the combinational two-way round-robin/fixed-priority winner selector.
- The counter and FSM stay in mem_arbiter.

Test Plan:
- Port 0 read burst alone, memory ready=1, valid latency 2:
  - grant=01 one cycle after ren;
  - 4 reads at 0x100..0x10C;
  - 4 o_p0_valid pulses;
  - IDLE after the last valid.
- Simultaneous port 0 read and port 1 write at 0x200, FIXED_PRIO=0, after reset:
  - port 0 granted first;
  - port 1 waits with o_p1_ready=0;
  - after port 0 drains, port 1 granted and o_mem_wen=1 with its wdata.
- Same stimulus with FIXED_PRIO=1:
  - port 1 granted first;
  - port 0 granted after the write completes.
- Memory withholds valid while the owner issues 5 reads:
  - 5th read held (ready=0, ren masked) until the first valid arrives;
  - out_cnt never exceeds 4.
- Owner drops ren with 2 reads outstanding:
  - state DRAIN;
  - port 1 request not granted until both valids are delivered to port 0.
- Reset asserted with out_cnt=3:
  - next cycle IDLE, all outputs 0;
  - a subsequent stray i_mem_valid is not forwarded to either port.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache memory-port arbiter: FSM encodings,
// requester indices and the line-size derived outstanding-read limit.
package mem_arbiter_pkg;

  localparam int WORD_W      = 32;
  localparam int LINE_WORDS  = 4;
  localparam int MAX_OUT_DEF = LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN   = 2'b01,
    DRAIN = 2'b10
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  function automatic logic [1:0] grant_of(port_t p);
    return (p == PORT_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Word-granular memory request/response bus; used both between a cache and
// the arbiter and between the arbiter and the external memory.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [WORD_W-1:0] addr;
  logic              ren;
  logic              wen;
  logic [WORD_W-1:0] wdata;
  logic              ready;
  logic [WORD_W-1:0] rdata;
  logic              valid;

  modport master (output addr, ren, wen, wdata, input ready, rdata, valid);
  modport slave  (input addr, ren, wen, wdata, output ready, rdata, valid);
endinterface

// File: rtl/mem_arb_pick.sv
// Two-way winner selector used when the arbiter is idle: round-robin against
// the previous winner, or fixed priority favouring the data-cache port.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  port_t      last_winner,
  output port_t      winner
);

  always_comb begin
    winner = PORT_I;
    if (req == 2'b11) begin
      if (FIXED_PRIO)
        winner = PORT_D;
      else
        winner = (last_winner == PORT_I) ? PORT_D : PORT_I;
    end else if (req[1]) begin
      winner = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between the I-cache (p0) and D-cache (p1),
// holding the grant until the owner stops requesting and its reads return.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_OUT    = MAX_OUT_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  mem_arbiter_if.master mem,
  output logic [1:0]    o_grant
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  arb_state_t       state_q, state_d;
  port_t            owner_q, owner_d;
  port_t            last_q, last_d;
  port_t            win;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]        req;
  logic              own_ren, own_wen, own_req;
  logic [WORD_W-1:0] own_addr, own_wdata;
  logic              active, in_own, full;
  logic              issue_ren, issue_wen, rd_acc, rsp, rdy;

  assign req = {p1.ren | p1.wen, p0.ren | p0.wen};

  mem_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req         (req),
    .last_winner (last_q),
    .winner      (win)
  );

  assign own_ren   = (owner_q == PORT_D) ? p1.ren   : p0.ren;
  assign own_wen   = (owner_q == PORT_D) ? p1.wen   : p0.wen;
  assign own_addr  = (owner_q == PORT_D) ? p1.addr  : p0.addr;
  assign own_wdata = (owner_q == PORT_D) ? p1.wdata : p0.wdata;
  assign own_req   = own_ren | own_wen;

  // Outputs are silenced while reset is held so a stale owner cannot leak out.
  assign active    = (state_q != IDLE) && !i_rst;
  assign in_own    = (state_q == OWN) && !i_rst;
  assign full      = (cnt_q == CNT_W'(MAX_OUT));
  assign issue_ren = in_own & own_ren & ~full;
  assign issue_wen = in_own & own_wen & ~full;
  assign rd_acc    = issue_ren & mem.ready;
  assign rsp       = mem.valid & (cnt_q != '0);
  assign rdy       = in_own & mem.ready & ~full;

  assign mem.addr  = active ? own_addr  : '0;
  assign mem.wdata = active ? own_wdata : '0;
  assign mem.ren   = issue_ren;
  assign mem.wen   = issue_wen;

  assign p0.ready  = rdy & (owner_q == PORT_I);
  assign p1.ready  = rdy & (owner_q == PORT_D);
  assign p0.valid  = active & rsp & (owner_q == PORT_I);
  assign p1.valid  = active & rsp & (owner_q == PORT_D);
  assign p0.rdata  = (active && owner_q == PORT_I) ? mem.rdata : '0;
  assign p1.rdata  = (active && owner_q == PORT_D) ? mem.rdata : '0;
  assign o_grant   = active ? grant_of(owner_q) : 2'b00;

  always_comb begin
    cnt_d = cnt_q;
    if (rd_acc && !rsp)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!rd_acc && rsp)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          owner_d = win;
          last_d  = win;
        end
      end
      OWN: begin
        if (!own_req)
          state_d = (cnt_d == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (own_req)
          state_d = OWN;
        else if (cnt_d == '0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= PORT_I;
      last_q  <= PORT_D;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for the basic burst and
// arbitration cases, then scripted sequences for stall, drain and reset.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic [1:0] grant_a, grant_b;

  mem_arbiter_if p0a ();
  mem_arbiter_if p1a ();
  mem_arbiter_if ma ();
  mem_arbiter_if p0b ();
  mem_arbiter_if p1b ();
  mem_arbiter_if mb ();

  mem_arbiter #(.MAX_OUT(4), .FIXED_PRIO(1'b0)) u0 (
    .i_clk(clk), .i_rst(rst), .p0(p0a), .p1(p1a), .mem(ma), .o_grant(grant_a)
  );

  mem_arbiter #(.MAX_OUT(4), .FIXED_PRIO(1'b1)) u1 (
    .i_clk(clk), .i_rst(rst), .p0(p0b), .p1(p1b), .mem(mb), .o_grant(grant_b)
  );

  assign p0b.addr  = p0a.addr;
  assign p0b.ren   = p0a.ren;
  assign p0b.wen   = p0a.wen;
  assign p0b.wdata = p0a.wdata;
  assign p1b.addr  = p1a.addr;
  assign p1b.ren   = p1a.ren;
  assign p1b.wen   = p1a.wen;
  assign p1b.wdata = p1a.wdata;
  assign mb.ready  = ma.ready;
  assign mb.valid  = ma.valid;
  assign mb.rdata  = ma.rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        rst;
    logic        p0_ren;
    logic [31:0] p0_addr;
    logic        p1_wen;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        m_ready;
    logic        m_valid;
    logic [31:0] m_rdata;
    logic [1:0]  e_grant;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_rdy;
    logic [1:0]  e_vld;
  } vec_t;

  vec_t tbl[$];
  int   n_pass;
  int   n_total;

  function automatic vec_t mk(int sel, int r, int p0r, int p0ad, int p1w, int p1ad,
                              int p1d, int mr, int mv, int md, int eg, int er,
                              int ew, int ea, int ed, int erdy, int evld);
    vec_t v;
    v.sel = 1'(sel);   v.rst = 1'(r);
    v.p0_ren = 1'(p0r); v.p0_addr = 32'(p0ad);
    v.p1_wen = 1'(p1w); v.p1_addr = 32'(p1ad); v.p1_wdata = 32'(p1d);
    v.m_ready = 1'(mr); v.m_valid = 1'(mv); v.m_rdata = 32'(md);
    v.e_grant = 2'(eg); v.e_ren = 1'(er); v.e_wen = 1'(ew);
    v.e_addr = 32'(ea); v.e_wdata = 32'(ed);
    v.e_rdy = 2'(erdy); v.e_vld = 2'(evld);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic run_row(input vec_t v, input int k);
    logic [1:0]  g;
    logic        mr, mw, r0, r1, v0, v1;
    logic [31:0] maddr, mwd, d0, d1;
    @(posedge clk); #1;
    rst = v.rst;
    p0a.ren = v.p0_ren; p0a.wen = 1'b0; p0a.addr = v.p0_addr; p0a.wdata = '0;
    p1a.ren = 1'b0; p1a.wen = v.p1_wen; p1a.addr = v.p1_addr; p1a.wdata = v.p1_wdata;
    ma.ready = v.m_ready; ma.valid = v.m_valid; ma.rdata = v.m_rdata;
    @(negedge clk);
    if (v.sel) begin
      g = grant_b; mr = mb.ren; mw = mb.wen; maddr = mb.addr; mwd = mb.wdata;
      r0 = p0b.ready; r1 = p1b.ready; v0 = p0b.valid; v1 = p1b.valid;
      d0 = p0b.rdata; d1 = p1b.rdata;
    end else begin
      g = grant_a; mr = ma.ren; mw = ma.wen; maddr = ma.addr; mwd = ma.wdata;
      r0 = p0a.ready; r1 = p1a.ready; v0 = p0a.valid; v1 = p1a.valid;
      d0 = p0a.rdata; d1 = p1a.rdata;
    end
    chk($sformatf("row%0d grant", k), 32'(g), 32'(v.e_grant));
    chk($sformatf("row%0d mem_ren", k), 32'(mr), 32'(v.e_ren));
    chk($sformatf("row%0d mem_wen", k), 32'(mw), 32'(v.e_wen));
    chk($sformatf("row%0d mem_addr", k), maddr, v.e_addr);
    chk($sformatf("row%0d mem_wdata", k), mwd, v.e_wdata);
    chk($sformatf("row%0d p0_ready", k), 32'(r0), 32'(v.e_rdy[0]));
    chk($sformatf("row%0d p1_ready", k), 32'(r1), 32'(v.e_rdy[1]));
    chk($sformatf("row%0d p0_valid", k), 32'(v0), 32'(v.e_vld[0]));
    chk($sformatf("row%0d p1_valid", k), 32'(v1), 32'(v.e_vld[1]));
    if (v.e_vld[0]) chk($sformatf("row%0d p0_rdata", k), d0, v.m_rdata);
    else if (!v.e_grant[0]) chk($sformatf("row%0d p0_rdata", k), d0, 32'h0);
    if (v.e_vld[1]) chk($sformatf("row%0d p1_rdata", k), d1, v.m_rdata);
    else if (!v.e_grant[1]) chk($sformatf("row%0d p1_rdata", k), d1, 32'h0);
  endtask

  // Drives one cycle of read-only traffic into u0/u1 and stops at the sample edge.
  task automatic drive(input int r, input int p0r, input int p0ad, input int p1r,
                       input int p1ad, input int mv, input int md);
    @(posedge clk); #1;
    rst = 1'(r);
    p0a.ren = 1'(p0r); p0a.wen = 1'b0; p0a.addr = 32'(p0ad); p0a.wdata = '0;
    p1a.ren = 1'(p1r); p1a.wen = 1'b0; p1a.addr = 32'(p1ad); p1a.wdata = '0;
    ma.ready = 1'b1; ma.valid = 1'(mv); ma.rdata = 32'(md);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    p0a.ren = 1'b0; p0a.wen = 1'b0; p0a.addr = '0; p0a.wdata = '0;
    p1a.ren = 1'b0; p1a.wen = 1'b0; p1a.addr = '0; p1a.wdata = '0;
    ma.ready = 1'b1; ma.valid = 1'b0; ma.rdata = '0;

    // Port 0 burst of four reads, response latency 2.
    tbl.push_back(mk(0,1, 0,0,      0,0,0, 1,0,0,     0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,      0,0,0, 1,0,0,     0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0, 1,'h100,  0,0,0, 1,0,0,     0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0, 1,'h100,  0,0,0, 1,0,0,     1,1,0,'h100,0,1,0));
    tbl.push_back(mk(0,0, 1,'h104,  0,0,0, 1,0,0,     1,1,0,'h104,0,1,0));
    tbl.push_back(mk(0,0, 1,'h108,  0,0,0, 1,1,'hD0,  1,1,0,'h108,0,1,1));
    tbl.push_back(mk(0,0, 1,'h10C,  0,0,0, 1,1,'hD1,  1,1,0,'h10C,0,1,1));
    tbl.push_back(mk(0,0, 0,0,      0,0,0, 1,1,'hD2,  1,0,0,0,0,1,1));
    tbl.push_back(mk(0,0, 0,0,      0,0,0, 1,1,'hD3,  1,0,0,0,0,0,1));
    tbl.push_back(mk(0,0, 0,0,      0,0,0, 1,0,0,     0,0,0,0,0,0,0));
    // Round-robin: p0 read vs p1 write, p0 first after reset.
    tbl.push_back(mk(0,1, 0,0,      0,0,0,              1,0,0,    0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0, 1,'h300,  1,'h200,'hDEADBEEF, 1,0,0,    0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0, 1,'h300,  1,'h200,'hDEADBEEF, 1,0,0,    1,1,0,'h300,0,1,0));
    tbl.push_back(mk(0,0, 0,0,      1,'h200,'hDEADBEEF, 1,0,0,    1,0,0,0,0,1,0));
    tbl.push_back(mk(0,0, 0,0,      1,'h200,'hDEADBEEF, 1,1,'hE0, 1,0,0,0,0,0,1));
    tbl.push_back(mk(0,0, 0,0,      1,'h200,'hDEADBEEF, 1,0,0,    0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,      1,'h200,'hDEADBEEF, 1,0,0,    2,0,1,'h200,'hDEADBEEF,2,0));
    tbl.push_back(mk(0,0, 0,0,      0,0,0,              1,0,0,    2,0,0,0,0,2,0));
    tbl.push_back(mk(0,0, 0,0,      0,0,0,              1,0,0,    0,0,0,0,0,0,0));
    // Fixed priority instance: p1 write wins, then p0 read.
    tbl.push_back(mk(1,1, 0,0,      0,0,0,              1,0,0,    0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0, 1,'h300,  1,'h200,'hDEADBEEF, 1,0,0,    0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0, 1,'h300,  1,'h200,'hDEADBEEF, 1,0,0,    2,0,1,'h200,'hDEADBEEF,2,0));
    tbl.push_back(mk(1,0, 1,'h300,  0,0,0,              1,0,0,    2,0,0,0,0,2,0));
    tbl.push_back(mk(1,0, 1,'h300,  0,0,0,              1,0,0,    0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0, 1,'h300,  0,0,0,              1,0,0,    1,1,0,'h300,0,1,0));
    tbl.push_back(mk(1,0, 0,0,      0,0,0,              1,0,0,    1,0,0,0,0,1,0));
    tbl.push_back(mk(1,0, 0,0,      0,0,0,              1,1,'hE1, 1,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,      0,0,0,              1,0,0,    0,0,0,0,0,0,0));

    foreach (tbl[k]) run_row(tbl[k], k);

    // Five reads with responses withheld: the fifth stalls at four outstanding,
    // then reset lands with three still outstanding.
    drive(1, 0,0,      0,0, 0,0);
    drive(0, 1,'h400,  0,0, 0,0);  chk("stall idle grant", 32'(grant_a), 32'h0);
    drive(0, 1,'h400,  0,0, 0,0);  chk("stall rd0 ready", 32'(p0a.ready), 32'h1);
    drive(0, 1,'h404,  0,0, 0,0);  chk("stall rd1 ren", 32'(ma.ren), 32'h1);
    drive(0, 1,'h408,  0,0, 0,0);  chk("stall rd2 ready", 32'(p0a.ready), 32'h1);
    drive(0, 1,'h40C,  0,0, 0,0);  chk("stall rd3 addr", ma.addr, 32'h40C);
    drive(0, 1,'h410,  0,0, 0,0);  chk("stall full ready", 32'(p0a.ready), 32'h0);
                                   chk("stall full ren", 32'(ma.ren), 32'h0);
                                   chk("stall full grant", 32'(grant_a), 32'h1);
    drive(0, 1,'h410,  0,0, 0,0);  chk("stall hold ready", 32'(p0a.ready), 32'h0);
    drive(0, 1,'h410,  0,0, 1,'hF0); chk("stall rsp valid", 32'(p0a.valid), 32'h1);
                                   chk("stall rsp rdata", p0a.rdata, 32'hF0);
                                   chk("stall rsp ready", 32'(p0a.ready), 32'h0);
    drive(0, 1,'h410,  0,0, 0,0);  chk("stall resume ren", 32'(ma.ren), 32'h1);
                                   chk("stall resume addr", ma.addr, 32'h410);
    drive(0, 0,0,      0,0, 1,'hF1); chk("stall drop grant", 32'(grant_a), 32'h1);
                                   chk("stall drop valid", 32'(p0a.valid), 32'h1);
    drive(1, 0,0,      0,0, 0,0);  chk("rst hold grant", 32'(grant_a), 32'h0);
    drive(0, 0,0,      0,0, 1,'hF2); chk("rst after grant", 32'(grant_a), 32'h0);
                                   chk("rst stray p0_valid", 32'(p0a.valid), 32'h0);
                                   chk("rst stray p1_valid", 32'(p1a.valid), 32'h0);
                                   chk("rst stray p0_rdata", p0a.rdata, 32'h0);
                                   chk("rst mem_ren", 32'(ma.ren), 32'h0);
    drive(0, 0,0,      0,0, 1,'hF3); chk("rst stray2 p0_valid", 32'(p0a.valid), 32'h0);

    // Owner drops with two reads outstanding; p1 waits for both responses.
    drive(1, 0,0,      0,0,     0,0);
    drive(0, 1,'h500,  0,0,     0,0);  chk("drain idle grant", 32'(grant_a), 32'h0);
    drive(0, 1,'h500,  0,0,     0,0);  chk("drain rd0 ren", 32'(ma.ren), 32'h1);
    drive(0, 1,'h504,  0,0,     0,0);  chk("drain rd1 addr", ma.addr, 32'h504);
    drive(0, 0,0,      1,'h600, 0,0);  chk("drain enter grant", 32'(grant_a), 32'h1);
                                       chk("drain p1_ready", 32'(p1a.ready), 32'h0);
                                       chk("drain no ren", 32'(ma.ren), 32'h0);
    drive(0, 0,0,      1,'h600, 1,'hC0); chk("drain rsp0 p0_valid", 32'(p0a.valid), 32'h1);
                                       chk("drain rsp0 p1_valid", 32'(p1a.valid), 32'h0);
                                       chk("drain rsp0 grant", 32'(grant_a), 32'h1);
    drive(0, 0,0,      1,'h600, 0,0);  chk("drain gap grant", 32'(grant_a), 32'h1);
                                       chk("drain gap p1_ready", 32'(p1a.ready), 32'h0);
    drive(0, 0,0,      1,'h600, 1,'hC1); chk("drain rsp1 p0_valid", 32'(p0a.valid), 32'h1);
                                       chk("drain rsp1 rdata", p0a.rdata, 32'hC1);
    drive(0, 0,0,      1,'h600, 0,0);  chk("drain release grant", 32'(grant_a), 32'h0);
    drive(0, 0,0,      1,'h600, 0,0);  chk("p1 own grant", 32'(grant_a), 32'h2);
                                       chk("p1 own ren", 32'(ma.ren), 32'h1);
                                       chk("p1 own addr", ma.addr, 32'h600);
                                       chk("p1 own ready", 32'(p1a.ready), 32'h1);
    drive(0, 0,0,      0,0,     0,0);  chk("p1 drain grant", 32'(grant_a), 32'h2);
    drive(0, 0,0,      0,0,     1,'hC2); chk("p1 rsp valid", 32'(p1a.valid), 32'h1);
                                       chk("p1 rsp rdata", p1a.rdata, 32'hC2);
                                       chk("p1 rsp p0_valid", 32'(p0a.valid), 32'h0);
    drive(0, 0,0,      0,0,     0,0);  chk("p1 release grant", 32'(grant_a), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
